// File: rtl/serial_ripple_subtractor.sv
// Bit-serial ripple-borrow subtractor: diff = a - b - bin, one bit per clock, borrow carried in a flop.
// Result valid SIZE edges after accept; held in DONE for any length of out_ready backpressure, no overlap.
module serial_ripple_subtractor #(
  parameter  int SIZE  = 4,
  localparam int IDX_W = $clog2(SIZE)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            bin,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [SIZE-1:0] diff,
  output logic [SIZE-1:0] borrow,
  output logic            bout,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(SIZE - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [SIZE-1:0]  a_q;
  logic [SIZE-1:0]  b_q;
  logic             br;

  logic a_bit, b_bit, d_bit, bw_bit;

  // Single full-subtractor cell, reused for every bit position over time.
  always_comb begin
    a_bit  = a_q[idx];
    b_bit  = b_q[idx];
    d_bit  = a_bit ^ b_bit ^ br;
    bw_bit = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      br     <= 1'b0;
      diff   <= '0;
      borrow <= '0;
      bout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q    <= a;
            b_q    <= b;
            br     <= bin;
            diff   <= '0;
            borrow <= '0;
            bout   <= 1'b0;
            idx    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          diff[idx]   <= d_bit;
          borrow[idx] <= bw_bit;
          br          <= bw_bit;
          // idx parks at the top bit instead of wrapping.
          if (idx == LAST) begin
            bout  <= bw_bit;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN);
  assign out_valid = (state == DONE);

endmodule

// File: doc/serial_ripple_subtractor.md
Name: serial_ripple_subtractor

Overview:
- Bit-serial ripple-borrow subtractor: computes diff = a - b - bin over SIZE bits, one bit position per clock.
- This is the subtraction counterpart to our combinational ripple-carry adder. Borrow ripples through time instead of through a gate chain.
- Operands enter on a valid/ready input handshake; results leave on a valid/ready output handshake.
- Used where area matters more than latency and a full-width adder/subtractor chain is unwanted.

Parameters:
- SIZE, 4, operand width in bits; legal range 2..32.
- IDX_W, $clog2(SIZE), width of the internal bit-index counter; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- a  input  SIZE  minuend; sampled only on the accept edge.
- b  input  SIZE  subtrahend; sampled only on the accept edge.
- bin  input  1  borrow-in to bit 0; sampled only on the accept edge.
- in_valid  input  1  a/b/bin are valid.
- in_ready  output  1  block can accept operands; high exactly in IDLE.
- diff  output  SIZE  difference, registered.
- borrow  output  SIZE  per-bit borrow-out vector; borrow[i] is the borrow out of bit i.
- bout  output  1  final borrow; equals borrow[SIZE-1].
- out_valid  output  1  diff/borrow/bout are valid; high exactly in DONE.
- out_ready  input  1  consumer accepts the result.
- busy  output  1  high in RUN.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, idx=0, diff=0, borrow=0, bout=0, operand registers=0, running borrow=0. Resulting outputs: out_valid=0, busy=0, in_ready=1.
- FSM states are IDLE, RUN, DONE.
- IDLE:
  - Accept edge is in_valid && in_ready. On it: latch a, b, bin; clear diff and borrow to 0; set idx=0 and running borrow br=bin; go to RUN.
  - in_valid low: stay in IDLE.
- RUN: each edge processes bit i=idx.
  - diff[i] <= a[i]^b[i]^br
  - borrow[i] <= (~a[i]&b[i]) | (~(a[i]^b[i])&br)
  - br <= the same borrow expression
  - idx <= idx+1
  - When i==SIZE-1, go to DONE on that edge. That edge also updates bout.
  - Bits above idx remain 0 while running.
- Latency: out_valid rises exactly SIZE rising edges after the accept edge. Example: SIZE=4 with accept at edge 0 gives out_valid high after edge 4.
- DONE:
  - Outputs held stable while out_ready is low (backpressure of any length).
  - On out_valid && out_ready: go to IDLE. diff, borrow and bout keep their values until the next accept.
- No overlap: in_ready is low in RUN and DONE. in_valid asserted then is ignored and no operands are latched. A new accept is possible on the first edge after the return to IDLE, i.e. minimum throughput is one result per SIZE+2 cycles.
- Operand inputs changing during RUN have no effect, because operands are internal copies.
- Arithmetic:
  - diff is (a - b - bin) mod 2^SIZE.
  - bout=1 iff a < b+bin, treating a and b as unsigned.
  - Result is identical to a ripple-borrow combinational chain, including the borrow vector.
- Reset during RUN or DONE: immediate return to reset values. The partial result is discarded and no out_valid is produced.
- idx never exceeds SIZE-1. The counter does not wrap while in RUN.

Test Plan:
- SIZE=4, a=7, b=5, bin=0, out_ready=1 -> out_valid high 4 edges after accept; diff=0010, borrow=0000, bout=0; in_ready returns high the cycle after the output handshake.
- a=4, b=2, bin=0 -> diff=0010, borrow=0010, bout=0. Then a=2, b=4, bin=0 -> diff=1110, borrow=1100, bout=1 (underflow wraps mod 16).
- a=9, b=1, bin=1 -> diff=0111, borrow=0111, bout=0. Then a=0, b=0, bin=1 -> diff=1111, borrow=1111, bout=1 (borrow ripples through all bits).
- Backpressure: out_ready held low 5 cycles after out_valid rises -> diff/borrow/bout/out_valid stable throughout. Toggling in_valid with new operands during RUN and DONE is ignored; the result still matches the first operands.
- Reset mid-op: deassert rst_n asynchronously (between edges) at idx=2 -> outputs go to 0 and in_ready to 1 immediately. After release, a new a=12, b=8, bin=1 transaction gives diff=0011, bout=0 with no stale bits.
- Random: 200 random a/b/bin transactions with random out_ready stalls -> each diff/bout matches the reference model a-b-bin; out_valid never asserts without a preceding accept.
